input_reader: RTL and testbench

Front-panel input reader: synchronizes and debounces a switch bus and a push-button, then delivers the captured switch word as a 32-bit `value` with a one-cycle `enable` strobe. It is the input-side counterpart to the counter/LED output path. It feeds `enable`/`value` consumers in `top`-level designs. Every flop is clocked on `posedge CLK` with asynchronous clear on `negedge RST`; no other clock edge is used.

---
 rtl/input_reader_pkg.sv | 13 +
 rtl/input_sync2.sv | 23 ++
 rtl/input_reader.sv | 143 ++++++++++++++
 tb/tb_input_reader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/input_reader_pkg.sv
// rtl/input_reader_pkg.sv - shared types and constants for the front-panel input reader
package input_reader_pkg;

   localparam int VALUE_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } btn_state_t;

endpackage

// File: rtl/input_sync2.sv
// rtl/input_sync2.sv - parameterized-width two-flop synchronizer for asynchronous inputs
module input_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/input_reader.sv
// rtl/input_reader.sv - debounced switch/button reader delivering a captured word with a press strobe
module input_reader
   import input_reader_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DB_CYCLES = 50000,
   parameter int CNT_W     = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [WIDTH-1:0]   sw_in,
   input  logic               btn_in,
   input  logic               value_ready,
   output logic               enable,
   output logic [VALUE_W-1:0] value,
   output logic               value_valid,
   output logic               overflow,
   output logic [WIDTH-1:0]   sw_db
);

   localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES - 1);

   logic [WIDTH-1:0] sw_sync;
   logic             btn_sync;
   logic [WIDTH-1:0] sw_last;
   logic [CNT_W-1:0] sw_cnt;

   btn_state_t       state;
   btn_state_t       state_next;
   logic [CNT_W-1:0] btn_cnt;
   logic [CNT_W-1:0] btn_cnt_next;
   logic             press;

   input_sync2 #(.WIDTH(WIDTH)) u_sw_sync (
      .CLK (CLK),
      .RST (RST),
      .d   (sw_in),
      .q   (sw_sync)
   );

   input_sync2 #(.WIDTH(1)) u_btn_sync (
      .CLK (CLK),
      .RST (RST),
      .d   (btn_in),
      .q   (btn_sync)
   );

   // Switch debounce: the counter saturates so a long-stable bus keeps reloading the same level.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sw_last <= '0;
         sw_cnt  <= '0;
         sw_db   <= '0;
      end else begin
         sw_last <= sw_sync;
         if (sw_sync != sw_last) begin
            sw_cnt <= '0;
         end else if (sw_cnt != DB_MAX) begin
            sw_cnt <= sw_cnt + CNT_W'(1);
         end
         if (sw_cnt == DB_MAX) begin
            sw_db <= sw_last;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         btn_cnt <= '0;
      end else begin
         state   <= state_next;
         btn_cnt <= btn_cnt_next;
      end
   end

   always_comb begin
      state_next   = state;
      btn_cnt_next = btn_cnt;
      press        = 1'b0;
      case (state)
         IDLE: begin
            if (btn_sync) begin
               state_next = PRESS_WAIT;
            end
         end
         PRESS_WAIT: begin
            if (!btn_sync) begin
               state_next = IDLE;
            end else if (btn_cnt == DB_MAX) begin
               state_next = PRESSED;
               press      = 1'b1;
            end else begin
               btn_cnt_next = btn_cnt + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!btn_sync) begin
               state_next = RELEASE_WAIT;
            end
         end
         RELEASE_WAIT: begin
            // Returning high here is release bounce, so no new strobe.
            if (btn_sync) begin
               state_next = PRESSED;
            end else if (btn_cnt == DB_MAX) begin
               state_next = IDLE;
            end else begin
               btn_cnt_next = btn_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (state_next != state) begin
         btn_cnt_next = '0;
      end
   end

   // A capture coinciding with value_ready wins over the consume.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         enable      <= 1'b0;
         value       <= '0;
         value_valid <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         enable <= press;
         if (press) begin
            if (!value_valid || value_ready) begin
               value       <= VALUE_W'(sw_db);
               value_valid <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end else if (value_valid && value_ready) begin
            value_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_input_reader.sv
// tb/tb_input_reader.sv - directed self-checking bench for input_reader with short debounce
module tb_input_reader;

   logic        CLK;
   logic        RST;
   logic [7:0]  sw_in;
   logic        btn_in;
   logic        value_ready;
   logic        enable;
   logic [31:0] value;
   logic        value_valid;
   logic        overflow;
   logic [7:0]  sw_db;

   int n_vec;
   int n_err;
   int en_count;

   input_reader #(
      .WIDTH     (8),
      .DB_CYCLES (4),
      .CNT_W     (16)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .sw_in       (sw_in),
      .btn_in      (btn_in),
      .value_ready (value_ready),
      .enable      (enable),
      .value       (value),
      .value_valid (value_valid),
      .overflow    (overflow),
      .sw_db       (sw_db)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (enable) en_count++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wait_sw(input logic [7:0] exp);
      for (int i = 0; i < 40 && sw_db !== exp; i++) tick(1);
      check("sw_db settle", {24'h0, sw_db}, {24'h0, exp});
   endtask

   task automatic press_release(input int hold, input int rel);
      btn_in = 1'b1;
      tick(hold);
      btn_in = 1'b0;
      tick(rel);
   endtask

   task automatic pulse_ready;
      value_ready = 1'b1;
      tick(1);
      value_ready = 1'b0;
   endtask

   task automatic do_reset;
      RST = 1'b0;
      tick(2);
      RST = 1'b1;
   endtask

   int base;
   int idle_bad;

   initial begin
      n_vec = 0; n_err = 0; en_count = 0;
      RST = 1'b0;
      sw_in = 8'($urandom);
      btn_in = 1'b1;
      value_ready = 1'($urandom);
      tick(3);
      check("rst outs", {28'h0, enable, value_valid, overflow, |value}, 32'h0);
      check("rst sw_db", {24'h0, sw_db}, 32'h0);

      sw_in = 8'h00; btn_in = 1'b0; value_ready = 1'b0;
      RST = 1'b1;
      idle_bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (enable || value_valid || overflow || value != 0 || sw_db != 0) idle_bad++;
      end
      check("post-rst idle", idle_bad, 0);

      // clean press: strobe exactly after edge 6
      sw_in = 8'hA5;
      wait_sw(8'hA5);
      btn_in = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         if (k == 5 || k == 6 || k == 7) check($sformatf("enable e%0d", k), {31'h0, enable}, {31'h0, k == 6});
         if (k == 6) begin
            check("clean value", value, 32'h0000_00A5);
            check("clean valid", {31'h0, value_valid}, 32'h1);
         end
      end
      pulse_ready();
      check("consume valid", {31'h0, value_valid}, 32'h0);
      btn_in = 1'b0;
      tick(12);

      // press bounce 1-0-1-0 then hold, then a short release bounce
      base = en_count;
      btn_in = 1'b1; tick(2); btn_in = 1'b0; tick(2);
      btn_in = 1'b1; tick(2); btn_in = 1'b0; tick(2);
      btn_in = 1'b1; tick(15);
      check("bounce one strobe", en_count - base, 1);
      base = en_count;
      btn_in = 1'b0; tick(2); btn_in = 1'b1; tick(3);
      btn_in = 1'b0; tick(15);
      check("release bounce", en_count - base, 0);
      pulse_ready();
      check("bounce consumed", {31'h0, value_valid}, 32'h0);

      // overflow: second press while unconsumed
      base = en_count;
      sw_in = 8'h01; wait_sw(8'h01);
      press_release(10, 12);
      sw_in = 8'h02; wait_sw(8'h02);
      press_release(10, 12);
      check("ovf strobes", en_count - base, 2);
      check("ovf value held", value, 32'h0000_0001);
      check("ovf flag", {31'h0, overflow}, 32'h1);
      pulse_ready();
      tick(5);
      check("ovf sticky", {31'h0, overflow}, 32'h1);
      check("ovf consumed", {31'h0, value_valid}, 32'h0);

      // simultaneous capture and consume
      do_reset();
      sw_in = 8'h01; wait_sw(8'h01);
      press_release(10, 12);
      check("sim first", value, 32'h0000_0001);
      sw_in = 8'h3C; wait_sw(8'h3C);
      btn_in = 1'b1;
      tick(6);
      value_ready = 1'b1;
      tick(1);
      value_ready = 1'b0;
      check("sim enable", {31'h0, enable}, 32'h1);
      check("sim value", value, 32'h0000_003C);
      tick(1);
      check("sim valid", {31'h0, value_valid}, 32'h1);
      check("sim no ovf", {31'h0, overflow}, 32'h0);
      btn_in = 1'b0;
      tick(12);

      // reset during PRESS_WAIT, button held through release
      btn_in = 1'b1;
      tick(4);
      RST = 1'b0;
      #1;
      check("mid rst outs", {28'h0, enable, value_valid, overflow, |value}, 32'h0);
      check("mid rst sw_db", {24'h0, sw_db}, 32'h0);
      tick(2);
      base = en_count;
      RST = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         if (k == 5 || k == 6 || k == 7) check($sformatf("rel enable e%0d", k), {31'h0, enable}, {31'h0, k == 6});
         if (k == 6) begin
            check("rel value", value, 32'h0);
            check("rel valid", {31'h0, value_valid}, 32'h1);
            check("rel sw_db", {24'h0, sw_db}, 32'h3C);
         end
      end
      tick(5);
      check("rel one strobe", en_count - base, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
